// File: rtl/fifo_pkg.sv
// Shared async-FIFO package: default pointer width, pointer type and
// Gray/binary helpers reused by the write- and read-side controllers.
package fifo_pkg;

    localparam int unsigned ADDRESS_SIZE_DEFAULT = 4;

    typedef logic [ADDRESS_SIZE_DEFAULT:0] ptr_t;

    // Binary to reflected Gray code.
    function automatic ptr_t bin2gray(input ptr_t bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Reflected Gray code to binary: each bit is the XOR of all Gray bits at or above it.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[ADDRESS_SIZE_DEFAULT] = gray[ADDRESS_SIZE_DEFAULT];
        for (int i = int'(ADDRESS_SIZE_DEFAULT) - 1; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter of parameterised width.
// Ports:
//   gray_i  Gray-coded input value
//   bin_o   binary equivalent
module gray2bin_conv #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Bit i of the binary value is the XOR-reduction of Gray bits WIDTH-1 down to i.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and full-flag controller for the async FIFO.
// Consumes the synchronized Gray read pointer and produces the memory write
// address, the Gray write pointer and full / almost-full / fill / overflow status.
// Ports:
//   wclk, wrst      write clock, synchronous active-high reset
//   winc            producer write request
//   wq2_read_ptr    synchronized Gray read pointer
//   waddr           memory write address
//   wen             memory write enable (combinational)
//   wptr            registered Gray write pointer
//   wfull           registered full flag
//   walmost_full    registered almost-full flag
//   wfill           registered (pessimistic) occupancy, 0..DEPTH
//   woverflow       sticky flag: write attempted while full
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE       = ADDRESS_SIZE_DEFAULT,
    parameter int unsigned ALMOST_FULL_THRESH = 2
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic                    winc,
    input  logic [ADDRESS_SIZE:0]   wq2_read_ptr,
    output logic [ADDRESS_SIZE-1:0] waddr,
    output logic                    wen,
    output logic [ADDRESS_SIZE:0]   wptr,
    output logic                    wfull,
    output logic                    walmost_full,
    output logic [ADDRESS_SIZE:0]   wfill,
    output logic                    woverflow
);

    localparam int unsigned PW       = ADDRESS_SIZE + 1;
    localparam int unsigned DEPTH    = 1 << ADDRESS_SIZE;
    localparam int unsigned AF_LEVEL = DEPTH - ALMOST_FULL_THRESH;

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wfill_q, wfill_d;
    logic          wfull_q, wfull_d;
    logic          walmost_full_q, walmost_full_d;
    logic          woverflow_q, woverflow_d;

    logic [PW-1:0] rbin;
    logic [PW-1:0] full_cmp;
    logic          accept;

    gray2bin_conv #(
        .WIDTH (PW)
    ) u_rptr_conv (
        .gray_i (wq2_read_ptr),
        .bin_o  (rbin)
    );

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign full_cmp = {~wq2_read_ptr[ADDRESS_SIZE:ADDRESS_SIZE-1],
                       wq2_read_ptr[ADDRESS_SIZE-2:0]};

    assign accept = winc & ~wfull_q;

    // Next pointer, status flags and sticky overflow.
    always_comb begin
        wbin_d         = wbin_q + PW'(accept);
        wptr_d         = (wbin_d >> 1) ^ wbin_d;
        wfill_d        = wbin_d - rbin;
        wfull_d        = (wptr_d == full_cmp);
        walmost_full_d = (wfill_d >= PW'(AF_LEVEL));
        woverflow_d    = woverflow_q | (winc & wfull_q);
    end

    // State registers; reset takes precedence over any write request.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wfill_q        <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wfill_q        <= wfill_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign waddr        = wbin_q[ADDRESS_SIZE-1:0];
    assign wen          = accept;
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wfill        = wfill_q;
    assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl (ADDRESS_SIZE=4, ALMOST_FULL_THRESH=2).
// Reference model tracks total writes and reads as plain integers.
module tb_wptr_full_ctrl;

    localparam int DEPTH = 16;
    localparam int THR   = 2;

    logic       clk = 1'b0;
    logic       wrst, winc;
    logic [4:0] wq2_read_ptr;
    logic [3:0] waddr;
    logic       wen;
    logic [4:0] wptr;
    logic       wfull, walmost_full;
    logic [4:0] wfill;
    logic       woverflow;

    wptr_full_ctrl #(
        .ADDRESS_SIZE       (4),
        .ALMOST_FULL_THRESH (THR)
    ) dut (
        .wclk         (clk),
        .wrst         (wrst),
        .winc         (winc),
        .wq2_read_ptr (wq2_read_ptr),
        .waddr        (waddr),
        .wen          (wen),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wfill        (wfill),
        .woverflow    (woverflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: wr/rd are unbounded counts of writes accepted and reads seen.
    int wr = 0;
    int rd = 0;
    int m_fill = 0;
    bit m_full = 1'b0;
    bit m_af = 1'b0;
    bit m_ovf = 1'b0;

    function automatic logic [4:0] to_gray(input int v);
        logic [4:0] b;
        b = 5'(v & 31);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("waddr", 32'(waddr), 32'(wr & 15));
        chk("wptr", 32'(wptr), 32'(to_gray(wr)));
        chk("wfull", 32'(wfull), 32'(m_full));
        chk("walmost_full", 32'(walmost_full), 32'(m_af));
        chk("wfill", 32'(wfill), 32'(m_fill));
        chk("woverflow", 32'(woverflow), 32'(m_ovf));
    endtask

    // One clock: drive at negedge, check wen, advance model at posedge, check outputs at next negedge.
    task automatic step(input bit rst, input bit inc);
        wrst = rst;
        winc = inc;
        wq2_read_ptr = to_gray(rd);
        #1;
        chk("wen", 32'(wen), 32'(inc && !m_full));
        @(posedge clk);
        if (rst) begin
            wr = 0; m_fill = 0; m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            if (inc && m_full) m_ovf = 1'b1;
            if (inc && !m_full) wr++;
            m_fill = wr - rd;
            m_full = (m_fill == DEPTH);
            m_af   = (m_fill >= DEPTH - THR);
        end
        @(negedge clk);
        chk_outputs();
    endtask

    task automatic do_reset();
        rd = 0;
        step(1'b1, 1'b1);
    endtask

    logic [4:0] prev_ptr;

    initial begin
        wrst = 1'b1; winc = 1'b0; wq2_read_ptr = '0;
        @(negedge clk);

        // Reset state, write request ignored on the reset edge.
        do_reset();
        do_reset();

        // Fill to full.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
        chk("full_wptr", 32'(wptr), 32'h18);
        chk("full_wfill", 32'(wfill), 32'd16);
        chk("full_flag", 32'(wfull), 32'd1);

        // Overflow attempts while full.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        chk("ovf_wptr", 32'(wptr), 32'h18);
        chk("ovf_sticky", 32'(woverflow), 32'd1);

        // Drain release: read pointer jumps to gray 4.
        rd = 4;
        step(1'b0, 1'b0);
        chk("drain_wfill", 32'(wfill), 32'd12);
        chk("drain_waddr", 32'(waddr), 32'd0);
        step(1'b0, 1'b1);
        chk("ovf_still", 32'(woverflow), 32'd1);

        // Almost-full threshold.
        do_reset();
        chk("ovf_cleared", 32'(woverflow), 32'd0);
        for (int i = 0; i < 13; i++) step(1'b0, 1'b1);
        chk("af_13", 32'(walmost_full), 32'd0);
        step(1'b0, 1'b1);
        chk("af_14", 32'(walmost_full), 32'd1);

        // Wraparound with read pointer trailing by 3.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            prev_ptr = wptr;
            rd = wr - 2;
            step(1'b0, 1'b1);
            chk("gray_step", 32'($countones(wptr ^ prev_ptr)), 32'd1);
            chk("wrap_fill", 32'(wfill), 32'd3);
        end

        // Mid-operation reset.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
        do_reset();
        chk("midrst_waddr", 32'(waddr), 32'd0);
        step(1'b0, 1'b1);
        chk("midrst_next", 32'(waddr), 32'd1);

        // Randomized traffic with a lagging, single-step read pointer.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (rd < wr && $urandom_range(0, 2) == 0) rd++;
            prev_ptr = wptr;
            step(1'b0, 1'($urandom_range(0, 3) != 0));
            chk("rand_gray", 32'($countones(wptr ^ prev_ptr) <= 1), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
Write-domain pointer and full-flag controller for the async FIFO. It sits directly downstream of the read-to-write pointer synchronizer and consumes its two-flop-synchronized Gray read pointer (wq2_read_ptr). It produces:
- the binary write address for the FIFO memory;
- the Gray write pointer sent to the write-to-read synchronizer;
- full, almost-full, fill-level and overflow status, all in the wclk domain.

Parameters:
ADDRESS_SIZE, 4, memory address width; FIFO depth DEPTH = 2**ADDRESS_SIZE.
ALMOST_FULL_THRESH, 2, free-slot count at or below which walmost_full asserts; legal range 1..DEPTH-1.

Ports:
wclk  input  1  write-domain clock.
wrst  input  1  synchronous, active-high reset, sampled on posedge wclk.
winc  input  1  write request from the producer.
wq2_read_ptr  input  ADDRESS_SIZE+1  synchronized Gray read pointer.
waddr  output  ADDRESS_SIZE  memory write address, wbin[ADDRESS_SIZE-1:0].
wen  output  1  memory write enable, combinational: winc & ~wfull.
wptr  output  ADDRESS_SIZE+1  registered Gray write pointer.
wfull  output  1  registered full flag.
walmost_full  output  1  registered almost-full flag.
wfill  output  ADDRESS_SIZE+1  registered occupancy estimate, 0..DEPTH.
woverflow  output  1  sticky error: a write was attempted while full.

Behaviour:
- Clocking and reset: one clock (wclk). Reset is synchronous and active-high (wrst). No asynchronous reset path.
- Reset values on the first posedge wclk with wrst=1: wbin=0, wptr=0, wfull=0, walmost_full=0, wfill=0, woverflow=0. Consequently waddr=0 and wen=0 while wfull=0 only if winc=0.
- Reset dominates: no write is accepted on a reset edge, even with winc=1.
- Internal binary pointer wbin is ADDRESS_SIZE+1 bits.
- Next-state pointer:
  - wbinnext = wbin + (winc & ~wfull), modulo 2**(ADDRESS_SIZE+1); wraps naturally from all-ones to 0.
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
- Every posedge (no reset): wbin <= wbinnext; wptr <= wgraynext.
- Accept latency: an accepted write takes effect at the same edge. waddr and wptr reflect the new pointer one cycle after acceptance.
- Read pointer conversion: rbin is the Gray-to-binary conversion of wq2_read_ptr, computed combinationally. Bit ADDRESS_SIZE passes through; each lower bit i = rbin[i+1] ^ gray[i].
- Full flag:
  - wfull <= (wgraynext == {~wq2_read_ptr[A:A-1], wq2_read_ptr[A-2:0]}), where A = ADDRESS_SIZE.
  - Full is therefore registered at the edge that accepts the DEPTH-th outstanding write.
- Fill level:
  - wfill <= (wbinnext - rbin) modulo 2**(A+1).
  - The value is pessimistic: the read pointer lags by the synchronizer latency, so wfill never under-reports.
- Almost-full: walmost_full <= ((wbinnext - rbin) >= DEPTH - ALMOST_FULL_THRESH).
- Full de-assertion: wfull and walmost_full de-assert only after wq2_read_ptr advances, at the first edge after the change. There is no combinational path from wq2_read_ptr to any output except through registers.
- Overflow: winc=1 while wfull=1 is rejected, i.e. wen=0 and the pointer is held. In that case woverflow <= 1. woverflow is cleared only by wrst.
- Simultaneous events:
  - A write plus a read-pointer advance in the same cycle gives fill = old+1-delta.
  - Full cannot assert if the read advance frees space.
- wq2_read_ptr is assumed Gray-coded and to change by at most one code per wclk. The block does not check this.

Decomposition:
- Shared package fifo_pkg holds:
  - constant ADDRESS_SIZE_DEFAULT;
  - typedef ptr_t, logic [ADDRESS_SIZE:0];
  - functions bin2gray and gray2bin, so they are reused by the read-side controller.
- One sub-module is natural: gray2bin_conv (parameterized width, purely combinational). It is instantiated for wq2_read_ptr.
- All other logic is flat in wptr_full_ctrl.

Test Plan:
- Fill to full (DEPTH=16, THRESH=2): reset, then 16 consecutive winc=1 cycles with wq2_read_ptr=0 -> wfull=1 after the 16th accepted edge; wptr=5'b11000 (gray 16); waddr=0; wfill=16; wen=0 next cycle.
- Overflow: after the previous case, hold winc=1 for 3 cycles -> wptr stays 5'b11000, wen=0, woverflow=1 and remains 1 until wrst.
- Almost-full: from reset, 14 writes with read pointer at 0 -> walmost_full=1 and wfill=14 after the 14th write; walmost_full=0 after 13.
- Drain release: while full, set wq2_read_ptr=5'b00110 (gray 4) -> next edge wfull=0, wfill=12, walmost_full=0; the following winc is accepted with waddr=0.
- Wraparound: 40 writes with the read pointer kept 3 behind (fed Gray) -> wbin wraps 31->0; wptr is always a single-bit Gray step; wfull never asserts; wfill=3 steady.
- Mid-operation reset: after 7 writes, assert wrst for one cycle with winc=1 -> all outputs 0 at that edge; the write is not counted; the next accepted write uses waddr=0.
